// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse character sequencing path.
//   SYM_W_DEF / CNT_W_DEF : default symbol width and element-count width
//   acc_state_t           : accumulator state (idle / collecting elements)
//   morse_char_t          : packed character record handed to the lookup stage
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int SYM_W_DEF = 5;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    ACC_IDLE    = 1'b0,
    ACC_COLLECT = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic                 space;
    logic                 error;
    logic [CNT_W_DEF-1:0] len;
    logic [SYM_W_DEF-1:0] symbol;
  } morse_char_t;

endpackage

// File: rtl/morse_symbol_accum.sv
// -----------------------------------------------------------------------------
// morse_symbol_accum
// Collects dot/dash elements into an indexed symbol code with a length counter
// and a sticky overflow flag. The outputs are the "next" view: the accumulator
// contents with this cycle's element already applied, so a gap arriving in the
// same cycle as an element can emit a character that includes it.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : empty the accumulator at the end of this cycle
//   i_elem       : a valid element (dot or dash) this cycle
//   i_dash       : element value (1 = dash, 0 = dot)
//   o_sym_nxt    : symbol code including this cycle's element
//   o_len_nxt    : element count including this cycle's element (saturates)
//   o_ovf_nxt    : overflow flag including this cycle's element
// -----------------------------------------------------------------------------
module morse_symbol_accum #(
  parameter int SYM_W = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_elem,
  input  logic             i_dash,
  output logic [SYM_W-1:0] o_sym_nxt,
  output logic [CNT_W-1:0] o_len_nxt,
  output logic             o_ovf_nxt
);

  logic [SYM_W-1:0] r_sym;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;

  logic [SYM_W-1:0] w_sym_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic             w_ovf_nxt;

  always_comb begin
    w_sym_nxt = r_sym;
    w_len_nxt = r_len;
    w_ovf_nxt = r_ovf;
    if (i_elem) begin
      if (r_len < CNT_W'(SYM_W)) begin
        for (int i = 0; i < SYM_W; i++) begin
          if (r_len == CNT_W'(i)) w_sym_nxt[i] = i_dash;
        end
        w_len_nxt = r_len + CNT_W'(1);
      end else begin
        // Full: the extra element is dropped, only its existence is recorded.
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_sym <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_sym <= w_sym_nxt;
      r_len <= w_len_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_sym_nxt = w_sym_nxt;
  assign o_len_nxt = w_len_nxt;
  assign o_ovf_nxt = w_ovf_nxt;

endmodule

// File: rtl/morse_char_controller.sv
// -----------------------------------------------------------------------------
// morse_char_controller
// Turns decoder element/gap pulses into whole characters presented once on a
// valid/ready output with space and error flags.
//   clk, reset_n        : clock, asynchronous active-low reset
//   dot, dash           : single-cycle element pulses (both high = ignored)
//   lg, wg              : letter-gap / word-gap pulses (both high = word gap)
//   char_ready          : consumer accepts the presented character
//   char_valid          : a character is presented
//   char_symbol         : element code, bit i = element i (1 = dash)
//   char_len            : number of elements
//   char_space          : character followed by a word space
//   char_error          : more than SYM_W elements were keyed
//   busy                : accumulator non-empty or a character is presented
//   dropped             : pulse, a character was lost to an occupied output
// -----------------------------------------------------------------------------
module morse_char_controller
  import morse_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dot,
  input  logic             dash,
  input  logic             lg,
  input  logic             wg,
  input  logic             char_ready,
  output logic             char_valid,
  output logic [SYM_W-1:0] char_symbol,
  output logic [CNT_W-1:0] char_len,
  output logic             char_space,
  output logic             char_error,
  output logic             busy,
  output logic             dropped
);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic             r_last_space;
  logic             w_last_space_nxt;

  logic             w_elem;
  logic             w_emit;
  logic             w_emit_space;
  logic             w_clr;
  logic             w_slot_free;

  logic [SYM_W-1:0] w_sym_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic             w_ovf_nxt;

  assign w_elem = dot ^ dash;

  morse_symbol_accum #(
    .SYM_W (SYM_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clr     (w_clr),
    .i_elem    (w_elem),
    .i_dash    (dash),
    .o_sym_nxt (w_sym_nxt),
    .o_len_nxt (w_len_nxt),
    .o_ovf_nxt (w_ovf_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ACC_IDLE;
      r_last_space <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_space <= w_last_space_nxt;
    end
  end

  // wg is tested before lg so that both together behave as a word gap.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_space_nxt = r_last_space;
    w_emit           = 1'b0;
    w_emit_space     = 1'b0;
    w_clr            = 1'b0;
    if (w_elem) w_last_space_nxt = 1'b0;
    case (r_state)
      ACC_IDLE: begin
        if (wg) begin
          // Only one space token per run of word gaps, unless an element
          // arrived alongside the gap and makes a real character.
          if (w_elem || !r_last_space) begin
            w_emit       = 1'b1;
            w_emit_space = 1'b1;
            w_clr        = 1'b1;
          end
          w_last_space_nxt = 1'b1;
        end else if (lg && w_elem) begin
          w_emit = 1'b1;
          w_clr  = 1'b1;
        end else if (w_elem) begin
          w_state_nxt = ACC_COLLECT;
        end
      end
      ACC_COLLECT: begin
        if (wg) begin
          w_emit           = 1'b1;
          w_emit_space     = 1'b1;
          w_clr            = 1'b1;
          w_last_space_nxt = 1'b1;
          w_state_nxt      = ACC_IDLE;
        end else if (lg) begin
          w_emit      = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = ACC_IDLE;
        end
      end
      default: w_state_nxt = ACC_IDLE;
    endcase
  end

  // The slot can take a new character when empty or being drained this cycle.
  assign w_slot_free = !char_valid || char_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_valid  <= 1'b0;
      char_symbol <= '0;
      char_len    <= '0;
      char_space  <= 1'b0;
      char_error  <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (w_emit && w_slot_free) begin
        char_valid  <= 1'b1;
        char_symbol <= w_sym_nxt;
        char_len    <= w_len_nxt;
        char_space  <= w_emit_space;
        char_error  <= w_ovf_nxt;
      end else if (w_emit) begin
        dropped <= 1'b1;
      end else if (char_valid && char_ready) begin
        char_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state == ACC_COLLECT) || char_valid;

endmodule

// File: tb/tb_morse_char_controller.sv
module tb_morse_char_controller;

  localparam int SYM_W = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0, char_ready = 1'b0;
  logic             char_valid;
  logic [SYM_W-1:0] char_symbol;
  logic [CNT_W-1:0] char_len;
  logic             char_space, char_error, busy, dropped;

  int checks = 0;
  int failures = 0;

  // Reference model: keyed elements kept as a plain list, output slot as fields.
  int               q[$];
  bit               m_last, m_valid, m_space, m_err, m_drop;
  logic [SYM_W-1:0] m_sym;
  logic [CNT_W-1:0] m_len;

  morse_char_controller #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dot         (dot),
    .dash        (dash),
    .lg          (lg),
    .wg          (wg),
    .char_ready  (char_ready),
    .char_valid  (char_valid),
    .char_symbol (char_symbol),
    .char_len    (char_len),
    .char_space  (char_space),
    .char_error  (char_error),
    .busy        (busy),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_last = 0; m_valid = 0; m_space = 0; m_err = 0; m_drop = 0;
    m_sym = '0; m_len = '0;
  endtask

  task automatic model_step(input bit d, input bit da, input bit l, input bit w, input bit r);
    bit elem, emit, sp, free;
    int n;
    elem = d ^ da; emit = 0; sp = 0;
    free = !m_valid || r;
    if (elem) begin q.push_back(int'(da)); m_last = 0; end
    if (w) begin
      if (q.size() > 0 || !m_last) begin emit = 1; sp = 1; end
      m_last = 1;
    end else if (l && q.size() > 0) begin
      emit = 1;
    end
    m_drop = 0;
    if (emit) begin
      if (free) begin
        n = (q.size() > SYM_W) ? SYM_W : q.size();
        m_valid = 1; m_space = sp; m_err = (q.size() > SYM_W);
        m_len = CNT_W'(n); m_sym = '0;
        for (int i = 0; i < n; i++) m_sym[i] = q[i][0];
      end else begin
        m_drop = 1;
      end
      q.delete();
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic drive(input bit d, input bit da, input bit l, input bit w, input bit r);
    dot = d; dash = da; lg = l; wg = w; char_ready = r;
    @(posedge clk);
    model_step(d, da, l, w, r);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error} !== '0) begin
      failures++;
      $display("FAIL reset_char got v=%b sym=%b len=%0d sp=%b err=%b want all 0", char_valid, char_symbol, char_len, char_space, char_error);
    end
    checks++;
    if ({busy, dropped} !== 2'b00) begin
      failures++;
      $display("FAIL reset_status got busy=%b dropped=%b want 0 0", busy, dropped);
    end
    reset_n = 1;
    model_reset();
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_lg_ignored got v=%b busy=%b want 0 0", char_valid, busy);
    end
  endtask

  task automatic test_letter_a();
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    checks++;
    if ({busy, char_valid} !== 2'b10) begin
      failures++;
      $display("FAIL a_collect got busy=%b v=%b want 1 0", busy, char_valid);
    end
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error} !== {1'b1, 5'b00010, 3'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL letter_a got v=%b sym=%b len=%0d sp=%b err=%b want 1 00010 2 0 0", char_valid, char_symbol, char_len, char_space, char_error);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if ({char_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL a_accepted got v=%b busy=%b want 0 0", char_valid, busy);
    end
  endtask

  task automatic test_word_space();
    repeat (4) drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error} !== {1'b1, 5'b00000, 3'd4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL h_space got v=%b sym=%b len=%0d sp=%b err=%b want 1 00000 4 1 0", char_valid, char_symbol, char_len, char_space, char_error);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL repeat_wg got v=%b want 0", char_valid);
    end
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space} !== {1'b1, 5'b00000, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL e_after_space got v=%b sym=%b len=%0d sp=%b want 1 00000 1 0", char_valid, char_symbol, char_len, char_space);
    end
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error} !== {1'b1, 5'b00000, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL space_token got v=%b sym=%b len=%0d sp=%b err=%b want 1 00000 0 1 0", char_valid, char_symbol, char_len, char_space, char_error);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    repeat (6) drive(0, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error} !== {1'b1, 5'b11111, 3'd5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overflow got v=%b sym=%b len=%0d sp=%b err=%b want 1 11111 5 0 1", char_valid, char_symbol, char_len, char_space, char_error);
    end
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_error} !== {1'b1, 5'b00000, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL after_overflow got v=%b sym=%b len=%0d err=%b want 1 00000 1 0", char_valid, char_symbol, char_len, char_error);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++;
    if ({dropped, char_valid, char_symbol, char_len} !== {1'b1, 1'b1, 5'b00000, 3'd1}) begin
      failures++;
      $display("FAIL t_dropped got drop=%b v=%b sym=%b len=%0d want 1 1 00000 1", dropped, char_valid, char_symbol, char_len);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({dropped, char_valid, char_symbol, char_len, busy} !== {1'b0, 1'b1, 5'b00000, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL e_held got drop=%b v=%b sym=%b len=%0d busy=%b want 0 1 00000 1 1", dropped, char_valid, char_symbol, char_len, busy);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if ({char_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL e_released got v=%b busy=%b want 0 0", char_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, dropped} !== {1'b1, 5'b00001, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL back_to_back got v=%b sym=%b len=%0d drop=%b want 1 00001 1 0", char_valid, char_symbol, char_len, dropped);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got v=%b want 0", char_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({char_valid, busy} !== 2'b11) begin
      failures++;
      $display("FAIL pre_reset got v=%b busy=%b want 1 1", char_valid, busy);
    end
    reset_n = 0;
    #1;
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error, busy, dropped} !== '0) begin
      failures++;
      $display("FAIL async_reset got v=%b sym=%b len=%0d sp=%b err=%b busy=%b drop=%b want all 0", char_valid, char_symbol, char_len, char_space, char_error, busy, dropped);
    end
    model_reset();
    reset_n = 1;
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 1);
    checks++;
    if ({char_valid, char_symbol, char_len, char_space, char_error, dropped} !== {1'b1, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL post_reset got v=%b sym=%b len=%0d sp=%b err=%b drop=%b want 1 00000 1 0 0 0", char_valid, char_symbol, char_len, char_space, char_error, dropped);
    end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit d, da, l, w, r;
    int sel;
    logic [SYM_W+CNT_W+4:0] got, exp;
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(0, 15));
      d  = (sel < 4) || (sel == 8);
      da = (sel >= 4 && sel < 8) || (sel == 8);
      l  = ($urandom_range(0, 6) == 0);
      w  = ($urandom_range(0, 12) == 0);
      r  = ($urandom_range(0, 2) != 0);
      drive(d, da, l, w, r);
      got = {char_valid, char_symbol, char_len, char_space, char_error, busy, dropped};
      exp = {m_valid, m_sym, m_len, m_space, m_err, (q.size() > 0) || m_valid, m_drop};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random cycle %0d got v/sym/len/sp/err/busy/drop=%b want %b", n, got, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_letter_a();
    test_word_space();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
